// File: rtl/calc_pkg.sv
// Shared types and constants for the switch-driven calculator sequencer.
package calc_pkg;

    typedef enum logic [2:0] {IDLE, ISSUE, CONVERT, SHOW, SHOW_ERR, HOLD} state_e;
    typedef enum logic [1:0] {HUND, TENS, ONES} dpos_e;

    localparam logic [2:0] OP_CLR      = 3'b111;
    localparam logic [3:0] DIG_E       = 4'hE;
    localparam int         DEF_DWELL   = 1000;
    localparam int         DEF_GAP     = 100;
    localparam int         DEF_TIMEOUT = 15;

    function automatic int max2(int a, int b);
        return (a > b) ? a : b;
    endfunction

    // Select one BCD digit by display position.
    function automatic logic [3:0] bcd_pick(dpos_e p, logic [3:0] h, logic [3:0] t, logic [3:0] o);
        case (p)
            HUND:    return h;
            TENS:    return t;
            default: return o;
        endcase
    endfunction

endpackage

// File: rtl/calc_bin2bcd.sv
// Iterative double-dabble: 8-bit binary to three BCD digits, one bit per cycle.
module calc_bin2bcd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       done,
    output logic [3:0] hund,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [7:0]  sh;
    logic [11:0] bcd;
    logic [2:0]  cnt;
    logic        run;

    // One shift-add-3 iteration on the {bcd, shift} register pair.
    function automatic logic [19:0] dd_step(logic [11:0] b, logic [7:0] s);
        logic [11:0] a;
        a = b;
        for (int n = 0; n < 3; n++)
            if (a[n*4 +: 4] >= 4'd5) a[n*4 +: 4] = a[n*4 +: 4] + 4'd3;
        return {a[10:0], s, 1'b0};
    endfunction

    // First iteration happens on the start edge, seven more follow; done pulses after the eighth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh   <= '0;
            bcd  <= '0;
            cnt  <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start && !run) begin
                {bcd, sh} <= dd_step(12'd0, bin);
                cnt       <= 3'd7;
                run       <= 1'b1;
            end else if (run) begin
                {bcd, sh} <= dd_step(bcd, sh);
                cnt       <= cnt - 1'b1;
                if (cnt == 3'd1) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

    assign hund = bcd[11:8];
    assign tens = bcd[7:4];
    assign ones = bcd[3:0];

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: "=" edge detect, ALU req/ack transaction, BCD digit scheduling.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int DWELL_CYCLES = DEF_DWELL,
    parameter int GAP_CYCLES   = DEF_GAP,
    parameter int ALU_TIMEOUT  = DEF_TIMEOUT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       eq_in,
    input  logic [2:0] op_in,
    input  logic [3:0] val_in,
    output logic       alu_req,
    output logic [2:0] alu_op,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic       alu_ack,
    input  logic [7:0] alu_result,
    input  logic       alu_err,
    output logic [3:0] digit_out,
    output logic       dp_out,
    output logic       blank_out,
    output logic       busy,
    output logic       err
);

    localparam int             CW       = $clog2(max2(DWELL_CYCLES, GAP_CYCLES) + 1);
    localparam int             TW       = $clog2(ALU_TIMEOUT + 1);
    localparam logic [CW-1:0]  DWELL_LD = CW'(DWELL_CYCLES - 1);
    localparam logic [CW-1:0]  GAP_LD   = CW'(GAP_CYCLES - 1);
    localparam logic [TW-1:0]  TO_LAST  = TW'(ALU_TIMEOUT - 1);

    state_e        state;
    dpos_e         pos, first_pos, next_pos;
    logic          eq_q, in_gap, conv_start, conv_done, accept;
    logic [7:0]    acc;
    logic [2:0]    op_r;
    logic [3:0]    val_r, b_h, b_t, b_o;
    logic [CW-1:0] cnt;
    logic [TW-1:0] tcnt;

    calc_bin2bcd u_bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (conv_start),
        .bin   (acc),
        .done  (conv_done),
        .hund  (b_h),
        .tens  (b_t),
        .ones  (b_o)
    );

    assign accept   = eq_in && !eq_q && (state == IDLE || state == HOLD);
    assign busy     = !(state == IDLE || state == HOLD);
    assign alu_op   = op_r;
    assign alu_a    = acc;
    assign alu_b    = {4'b0, val_r};
    assign next_pos = (pos == HUND) ? TENS : ONES;

    // Leading-zero suppression picks where the digit sequence starts.
    always_comb begin
        first_pos = ONES;
        if (b_h != 4'd0)      first_pos = HUND;
        else if (b_t != 4'd0) first_pos = TENS;
    end

    // Main sequencer; the single cnt times every dwell and gap.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            pos        <= HUND;
            eq_q       <= 1'b0;
            in_gap     <= 1'b0;
            conv_start <= 1'b0;
            acc        <= '0;
            op_r       <= '0;
            val_r      <= '0;
            cnt        <= '0;
            tcnt       <= '0;
            alu_req    <= 1'b0;
            err        <= 1'b0;
            digit_out  <= '0;
            dp_out     <= 1'b0;
            blank_out  <= 1'b1;
        end else begin
            eq_q       <= eq_in;
            conv_start <= 1'b0;
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        err       <= 1'b0;
                        op_r      <= op_in;
                        val_r     <= val_in;
                        blank_out <= 1'b1;
                        dp_out    <= 1'b0;
                        if (op_in != OP_CLR) begin
                            state   <= ISSUE;
                            alu_req <= 1'b1;
                            tcnt    <= '0;
                        end else begin
                            acc        <= '0;
                            state      <= CONVERT;
                            conv_start <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (alu_ack && !alu_err) begin
                        alu_req    <= 1'b0;
                        acc        <= alu_result;
                        state      <= CONVERT;
                        conv_start <= 1'b1;
                    end else if (alu_ack || tcnt == TO_LAST) begin
                        alu_req   <= 1'b0;
                        err       <= 1'b1;
                        state     <= SHOW_ERR;
                        digit_out <= DIG_E;
                        dp_out    <= 1'b0;
                        blank_out <= 1'b0;
                        cnt       <= DWELL_LD;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
                CONVERT: begin
                    if (conv_done) begin
                        state     <= SHOW;
                        pos       <= first_pos;
                        in_gap    <= 1'b0;
                        digit_out <= bcd_pick(first_pos, b_h, b_t, b_o);
                        dp_out    <= (first_pos == ONES);
                        blank_out <= 1'b0;
                        cnt       <= DWELL_LD;
                    end
                end
                SHOW: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else if (in_gap) begin
                        in_gap    <= 1'b0;
                        pos       <= next_pos;
                        digit_out <= bcd_pick(next_pos, b_h, b_t, b_o);
                        dp_out    <= (next_pos == ONES);
                        blank_out <= 1'b0;
                        cnt       <= DWELL_LD;
                    end else if (pos == ONES) begin
                        state <= HOLD;
                    end else begin
                        in_gap    <= 1'b1;
                        blank_out <= 1'b1;
                        dp_out    <= 1'b0;
                        cnt       <= GAP_LD;
                    end
                end
                SHOW_ERR: begin
                    if (cnt != '0) cnt <= cnt - 1'b1;
                    else           state <= HOLD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomized self-checking bench for calc_seq_ctrl with a behavioural calculator model.
module tb_calc_seq_ctrl;

    localparam int DW = 4;
    localparam int GP = 2;
    localparam int TO = 15;

    logic       clk = 1'b0, rst_n = 1'b0, eq_in = 1'b0;
    logic [2:0] op_in = '0;
    logic [3:0] val_in = '0;
    logic       alu_ack = 1'b0, alu_err = 1'b0;
    logic [7:0] alu_result = '0;
    logic       alu_req, dp_out, blank_out, busy, err;
    logic [2:0] alu_op;
    logic [7:0] alu_a, alu_b;
    logic [3:0] digit_out;

    int vectors = 0, miscompares = 0;
    int m_acc = 0;
    bit m_err = 1'b0;
    int seen[$];

    calc_seq_ctrl #(.DWELL_CYCLES(DW), .GAP_CYCLES(GP), .ALU_TIMEOUT(TO)) dut (
        .clk(clk), .rst_n(rst_n), .eq_in(eq_in), .op_in(op_in), .val_in(val_in),
        .alu_req(alu_req), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_ack(alu_ack), .alu_result(alu_result), .alu_err(alu_err),
        .digit_out(digit_out), .dp_out(dp_out), .blank_out(blank_out),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // What the external ALU answers for a given op; the controller must store it verbatim.
    function automatic int alu_fn(int op, int a, int b);
        int r;
        case (op)
            0: r = a + b;
            1: r = a - b;
            2: r = a * b;
            3: r = (b != 0) ? a / b : 0;
            4: r = a & b;
            5: r = a | b;
            default: r = a ^ b;
        endcase
        return r & 255;
    endfunction

    // One press: drive "=", play the ALU, then follow the whole display sequence into HOLD.
    // delay < 0 means the ALU never acks.
    task automatic press(input int op, input int val, input int delay, input bit ferr,
                         input int res, input bit hold_eq, input bit toggle);
        int eb[$], ed[$], ep[$], dl[$];
        int k, n, h, t, o;
        bit fin, prev_blank;
        @(negedge clk);
        chk("idle_busy", busy, 0);
        eq_in  = 1'b1;
        op_in  = 3'(op);
        val_in = 4'(val);
        @(negedge clk);
        if (!hold_eq) eq_in = 1'b0;
        op_in  = 3'($urandom_range(7));
        val_in = 4'($urandom_range(15));
        m_err  = 1'b0;
        chk("err_cleared", err, 0);
        if (op != 7) begin
            k = 0;
            fin = 1'b0;
            while (!fin) begin
                chk("req_high", alu_req, 1);
                chk("alu_op", alu_op, op);
                chk("alu_a", alu_a, m_acc);
                chk("alu_b", alu_b, val);
                chk("busy_issue", busy, 1);
                if (k == delay) begin
                    alu_ack    = 1'b1;
                    alu_err    = ferr;
                    alu_result = 8'(res);
                end
                @(negedge clk);
                alu_ack    = 1'b0;
                alu_err    = 1'b0;
                alu_result = 8'($urandom_range(255));
                k++;
                if (delay >= 0 && k == delay + 1) fin = 1'b1;
                if (delay < 0 && k == TO) fin = 1'b1;
            end
            chk("req_drop", alu_req, 0);
            if (delay < 0 || ferr) m_err = 1'b1;
            else                   m_acc = res;
        end else begin
            m_acc = 0;
        end
        chk("err_flag", err, m_err);
        n = 0;
        while (blank_out === 1'b1 && n < 40) begin
            chk("busy_wait", busy, 1);
            chk("no_req_wait", alu_req, 0);
            @(negedge clk);
            n++;
        end
        chk("display_start", blank_out, 0);
        // Expected display trace straight from the digit rules.
        if (m_err) begin
            repeat (DW) begin eb.push_back(0); ed.push_back(14); ep.push_back(0); end
        end else begin
            h = m_acc / 100; t = (m_acc / 10) % 10; o = m_acc % 10;
            if (h != 0)      dl = '{h, t, o};
            else if (t != 0) dl = '{t, o};
            else             dl = '{o};
            foreach (dl[i]) begin
                repeat (DW) begin eb.push_back(0); ed.push_back(dl[i]); ep.push_back(i == dl.size() - 1); end
                if (i != dl.size() - 1)
                    repeat (GP) begin eb.push_back(1); ed.push_back(-1); ep.push_back(0); end
            end
        end
        seen.delete();
        prev_blank = 1'b1;
        foreach (eb[j]) begin
            chk("busy_show", busy, 1);
            chk("no_req_show", alu_req, 0);
            chk("blank", blank_out, eb[j]);
            chk("dp", dp_out, ep[j]);
            if (ed[j] >= 0) chk("digit", digit_out, ed[j]);
            if (!blank_out && prev_blank) seen.push_back(int'(digit_out));
            prev_blank = blank_out;
            if (toggle) eq_in = 1'($urandom_range(1));
            @(negedge clk);
        end
        if (toggle) eq_in = 1'b0;
        repeat (hold_eq ? 6 : 3) begin
            chk("hold_busy", busy, 0);
            chk("hold_blank", blank_out, 0);
            chk("hold_digit", digit_out, m_err ? 14 : m_acc % 10);
            chk("hold_dp", dp_out, !m_err);
            chk("hold_err", err, m_err);
            chk("hold_req", alu_req, 0);
            @(negedge clk);
        end
        if (hold_eq) eq_in = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int op, val, r, dly;
        bit fe;
        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_blank", blank_out, 1);
        chk("rst_req", alu_req, 0);
        chk("rst_err", err, 0);
        chk("rst_digit", digit_out, 0);
        chk("rst_dp", dp_out, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        rst_n = 1'b1;

        press(0, 5, 1, 1'b0, 5, 1'b0, 1'b0);
        chk("t1_ndig", seen.size(), 1);
        chk("t1_dig0", seen[0], 5);

        press(0, 9, 2, 1'b0, 14, 1'b0, 1'b0);
        chk("t2_ndig", seen.size(), 2);
        chk("t2_dig0", seen[0], 1);
        chk("t2_dig1", seen[1], 4);

        press(2, 7, 0, 1'b0, 203, 1'b0, 1'b1);
        chk("t3_ndig", seen.size(), 3);
        chk("t3_dig0", seen[0], 2);
        chk("t3_dig1", seen[1], 0);
        chk("t3_dig2", seen[2], 3);

        press(0, 1, -1, 1'b0, 0, 1'b0, 1'b0);
        chk("t4_ndig", seen.size(), 1);
        chk("t4_dig0", seen[0], 14);

        press(3, 0, 1, 1'b1, 0, 1'b0, 1'b0);
        press(7, 0, 0, 1'b0, 0, 1'b1, 1'b0);
        chk("t5_ndig", seen.size(), 1);
        chk("t5_dig0", seen[0], 0);
        press(0, 4, 0, 1'b0, 4, 1'b0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = $urandom_range(7);
            val = $urandom_range(15);
            r   = $urandom_range(9);
            dly = (r == 0) ? -1 : int'($urandom_range(3));
            fe  = (r == 1);
            press(op, val, dly, fe, alu_fn(op, m_acc, val), 1'b0, 1'($urandom_range(1)));
        end

        // Reset in the middle of an outstanding request.
        @(negedge clk);
        eq_in = 1'b1; op_in = 3'd0; val_in = 4'd3;
        @(negedge clk);
        eq_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_req", alu_req, 1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("rr_req", alu_req, 0);
        chk("rr_blank", blank_out, 1);
        chk("rr_busy", busy, 0);
        chk("rr_err", err, 0);
        chk("rr_alu_a", alu_a, 0);
        chk("rr_alu_b", alu_b, 0);
        rst_n = 1'b1;
        m_acc = 0;
        m_err = 1'b0;
        press(0, 2, 1, 1'b0, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Sequencing controller for the switch-driven calculator on the Tiny Tapeout FPGA board. It edge-detects the "=" switch and latches op/value. It issues one transaction to the external ALU datapath over a req/ack handshake and keeps the 8-bit accumulator. It converts the result to BCD and schedules the digits onto the single 7-segment display as hundreds, then tens, then ones, with a dwell time per digit.

Parameters:
DWELL_CYCLES, 1000, cycles each digit is displayed (Makerchip sim uses 4)
GAP_CYCLES, 100, blank cycles between digits (sim uses 2)
ALU_TIMEOUT, 15, max cycles alu_req may stay high without alu_ack

Ports:
clk  in  1  system clock
rst_n  in  1  reset, synchronous, active-low
eq_in  in  1  "=" switch (ui_in[7]), already synchronized/debounced
op_in  in  3  operation select (ui_in[6:4])
val_in  in  4  operand (ui_in[3:0])
alu_req  out  1  transaction request to ALU
alu_op  out  3  latched op, stable while alu_req=1
alu_a  out  8  accumulator operand, stable while alu_req=1
alu_b  out  8  {4'b0, latched val_in}, stable while alu_req=1
alu_ack  in  1  ALU result valid; may be high in the same cycle as alu_req rises
alu_result  in  8  ALU result, sampled when alu_ack=1
alu_err  in  1  ALU error (e.g. divide by zero), sampled with alu_ack
digit_out  out  4  BCD digit to segment decoder; 4'hE = "E"
dp_out  out  1  decimal point, marks the final (ones) digit
blank_out  out  1  display blank
busy  out  1  high in every state except IDLE and HOLD
err  out  1  sticky error indication, cleared by the next accepted press

Behaviour:
- Reset (rst_n=0 at a clk edge) overrides everything, including mid-transaction:
  - state=IDLE, acc=0, alu_req=0, alu_op=0, alu_a=0, alu_b=0
  - digit_out=0, dp_out=0, blank_out=1, busy=0, err=0, eq history=0
  - an in-flight request is dropped with no wait for ack
- press = eq_in & ~eq_q, where eq_q is a registered copy of eq_in. A press is accepted only in IDLE or HOLD. Presses in any other state are discarded, not queued.
- On an accepted press, op/val are latched and err is cleared.
  - op_in != 3'b111: next state ISSUE, alu_req=1 from the next cycle.
  - op_in == 3'b111 (CLEAR): acc<=0, no ALU transaction, next state CONVERT.
- ISSUE:
  - alu_req is held high until alu_ack is sampled high, then drops the following cycle.
  - ack with err=0: acc<=alu_result, then CONVERT.
  - ack with alu_err=1: acc unchanged, err<=1, then SHOW_ERR.
  - ALU_TIMEOUT cycles without ack: alu_req<=0, err<=1, then SHOW_ERR.
- CONVERT: start the calc_bin2bcd sub-module on acc. Conversion takes exactly 8 cycles (shift-add-3), then SHOW.
- SHOW:
  - Digit order: hundreds, tens, ones.
  - Leading-zero suppression: hundreds is skipped if 0; tens is skipped if hundreds=0 and tens=0. The ones digit is always shown.
  - Each digit is driven for DWELL_CYCLES with blank_out=0.
  - Each non-final digit is followed by GAP_CYCLES with blank_out=1.
  - dp_out=1 only while the ones digit is shown.
- HOLD: the ones digit with dp_out=1 stays displayed continuously until the next accepted press or reset.
- SHOW_ERR: digit_out=4'hE, dp_out=0, blank_out=0 for DWELL_CYCLES, then HOLD showing "E".
- Arithmetic: acc is 8-bit. Wrap-around or overflow is the ALU's responsibility; the controller stores alu_result verbatim. Range 0..255 gives at most 3 digits.
- The dwell/gap counter is a single down-counter sized to max(DWELL_CYCLES, GAP_CYCLES). It is reloaded on each state/digit change.

Decomposition:
- Package calc_pkg:
  - state enum {IDLE, ISSUE, CONVERT, SHOW, SHOW_ERR, HOLD}
  - digit-position enum {HUND, TENS, ONES}
  - OP_CLR=3'b111, DIG_E=4'hE
  - default DWELL/GAP/timeout constants
- Sub-module calc_bin2bcd:
  - 8-bit binary to 3x4-bit BCD, iterative double-dabble
  - start/done handshake, 8-cycle latency, synchronous active-low reset

Test Plan:
- Reset, then press with op=0 (add), val=5, ALU acks after 1 cycle with 5 -> alu_a=0, alu_b=5 during req; acc=5; only "5" shown, dp_out=1; HOLD displays 5.
- acc=5, press add val=9 with a model ALU returning 14 -> "1" for 4 cycles, blank 2 cycles, "4" with dp_out=1; hundreds suppressed.
- ALU model returns 203 -> digits 2, 0, 3 in order; the middle 0 is displayed, not suppressed.
- alu_ack never asserted -> alu_req drops after exactly 15 cycles; err=1; digit_out=4'hE; acc unchanged.
- Press op=3'b111 while acc=203 -> no alu_req pulse; acc=0; display "0" with dp_out=1. Hold eq_in high for 20 cycles -> exactly one press accepted.
- Toggle eq_in during SHOW -> ignored, no alu_req. Assert rst_n=0 while alu_req=1 -> next cycle alu_req=0, blank_out=1, acc=0.
